// File: rtl/key_conditioner_if.sv
// Pushbutton conditioner signal bundle: raw key in, clean pulses and level out.
// The conditioner is the master; the downstream FSM consumes as slave.
interface key_conditioner_if;
    logic key_n;
    logic enter;
    logic override;
    logic key_down;

    modport master (
        input  key_n,
        output enter,
        output override,
        output key_down
    );

    modport slave (
        output key_n,
        input  enter,
        input  override,
        input  key_down
    );
endinterface

// File: rtl/key_conditioner.sv
// Turns a raw active-low pushbutton into a debounced level plus single-cycle
// enter (short press, on release) and override (long press, at threshold) pulses.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | key released, waiting for a debounced press
// PRESSED   | key held, hold timer running towards the long-press threshold
// LONG_HELD | override already issued, waiting for release (no enter)
module key_conditioner #(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int DEBOUNCE_MS   = 10,
    parameter int LONG_PRESS_MS = 3000
) (
    input logic               clk,
    input logic               reset_n,
    key_conditioner_if.master kif
);
    localparam int DEB_CYCLES  = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYCLES = CLK_FREQ_HZ / 1000 * LONG_PRESS_MS;
    localparam int DEB_W       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int LONG_W      = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PRESSED   = 2'd1;
    localparam logic [1:0] LONG_HELD = 2'd2;

    if (DEB_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_timing
        $error("key_conditioner: debounce and long-press cycle counts must be >= 1");
    end

    logic              sync_ff1;
    logic              sync_ff2;
    logic              sync_pressed;
    logic              deb_level;
    logic [DEB_W-1:0]  deb_cnt;
    logic              deb_rise;
    logic [1:0]        state;
    logic [LONG_W-1:0] hold_cnt;
    logic              enter_q;
    logic              override_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff1 <= 1'b1;
            sync_ff2 <= 1'b1;
        end else begin
            sync_ff1 <= kif.key_n;
            sync_ff2 <= sync_ff1;
        end
    end

    assign sync_pressed = ~sync_ff2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_level <= 1'b0;
            deb_cnt   <= '0;
        end else if (sync_pressed == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_level <= sync_pressed;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Press is taken from the debounce update itself so hold timing starts
    // on the same edge key_down rises; release is observed from the level.
    assign deb_rise = sync_pressed & ~deb_level & (deb_cnt == DEB_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            enter_q    <= 1'b0;
            override_q <= 1'b0;
        end else begin
            enter_q    <= 1'b0;
            override_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (deb_rise) begin
                        state    <= PRESSED;
                        hold_cnt <= '0;
                    end
                end
                PRESSED: begin
                    // Threshold is tested first so a release on the same
                    // cycle still counts as a long press.
                    if (hold_cnt == LONG_LAST) begin
                        override_q <= 1'b1;
                        state      <= deb_level ? LONG_HELD : IDLE;
                    end else if (!deb_level) begin
                        enter_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (!deb_level) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign kif.key_down = deb_level;
    assign kif.enter    = enter_q;
    assign kif.override = override_q;
endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEB_CYCLES=4, LONG_CYCLES=20.
// Edge 0 is the clock edge just before key_n changes; sampling is 1 ns after each edge.
module tb_key_conditioner;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    int   n_enter;
    int   n_ovr;
    int   n_both;
    int   n_wide;
    logic enter_d;
    logic ovr_d;
    int   e0;
    int   o0;

    key_conditioner_if kif();

    key_conditioner #(
        .CLK_FREQ_HZ  (1000),
        .DEBOUNCE_MS  (4),
        .LONG_PRESS_MS(20)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .kif    (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_enter = 0;
        n_ovr   = 0;
        n_both  = 0;
        n_wide  = 0;
        enter_d = 1'b0;
        ovr_d   = 1'b0;
    end

    always @(negedge clk) begin
        if (kif.enter) n_enter++;
        if (kif.override) n_ovr++;
        if (kif.enter && kif.override) n_both++;
        if ((kif.enter && enter_d) || (kif.override && ovr_d)) n_wide++;
        enter_d = kif.enter;
        ovr_d   = kif.override;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mark();
        e0 = n_enter;
        o0 = n_ovr;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        kif.key_n = 1'b1;
        tick(3);
        chk("rst_key_down", 32'(kif.key_down), 0);
        chk("rst_enter", 32'(kif.enter), 0);
        chk("rst_override", 32'(kif.override), 0);
        reset_n = 1'b1;
        tick(5);

        // Clean short press: low for 10 cycles
        mark();
        kif.key_n = 1'b0;
        tick(5);
        chk("short_kd_e5", 32'(kif.key_down), 0);
        tick(1);
        chk("short_kd_e6", 32'(kif.key_down), 1);
        tick(4);
        kif.key_n = 1'b1;
        tick(6);
        chk("short_kd_rel", 32'(kif.key_down), 0);
        chk("short_enter_e6", 32'(kif.enter), 0);
        tick(1);
        chk("short_enter_e7", 32'(kif.enter), 1);
        tick(1);
        chk("short_enter_e8", 32'(kif.enter), 0);
        tick(5);
        chk("short_enter_cnt", 32'(n_enter - e0), 1);
        chk("short_ovr_cnt", 32'(n_ovr - o0), 0);

        // Bounce: toggle every 2 cycles for 20 cycles
        mark();
        for (int i = 0; i < 5; i++) begin
            kif.key_n = 1'b0;
            tick(2);
            chk("bounce_kd_lo", 32'(kif.key_down), 0);
            kif.key_n = 1'b1;
            tick(2);
            chk("bounce_kd_hi", 32'(kif.key_down), 0);
        end
        tick(10);
        chk("bounce_kd_end", 32'(kif.key_down), 0);
        chk("bounce_enter_cnt", 32'(n_enter - e0), 0);
        chk("bounce_ovr_cnt", 32'(n_ovr - o0), 0);

        // Long press: held 40 cycles, override 20 cycles after key_down rises
        mark();
        kif.key_n = 1'b0;
        tick(6);
        chk("long_kd_e6", 32'(kif.key_down), 1);
        tick(19);
        chk("long_ovr_e25", 32'(kif.override), 0);
        tick(1);
        chk("long_ovr_e26", 32'(kif.override), 1);
        tick(1);
        chk("long_ovr_e27", 32'(kif.override), 0);
        chk("long_state_held", 32'(dut.state), 2);
        tick(13);
        kif.key_n = 1'b1;
        tick(12);
        chk("long_enter_cnt", 32'(n_enter - e0), 0);
        chk("long_ovr_cnt", 32'(n_ovr - o0), 1);
        chk("long_state_idle", 32'(dut.state), 0);

        // Boundary: debounced release lands on hold_cnt == 19
        mark();
        kif.key_n = 1'b0;
        tick(19);
        kif.key_n = 1'b1;
        tick(7);
        chk("bnd19_ovr_e26", 32'(kif.override), 1);
        chk("bnd19_enter_e26", 32'(kif.enter), 0);
        tick(10);
        chk("bnd19_enter_cnt", 32'(n_enter - e0), 0);
        chk("bnd19_ovr_cnt", 32'(n_ovr - o0), 1);
        chk("bnd19_state", 32'(dut.state), 0);

        // Boundary: release one cycle earlier gives enter only
        mark();
        kif.key_n = 1'b0;
        tick(18);
        kif.key_n = 1'b1;
        tick(7);
        chk("bnd18_enter_e25", 32'(kif.enter), 1);
        chk("bnd18_ovr_e25", 32'(kif.override), 0);
        tick(10);
        chk("bnd18_enter_cnt", 32'(n_enter - e0), 1);
        chk("bnd18_ovr_cnt", 32'(n_ovr - o0), 0);

        // Reset mid-press, key still held afterwards
        mark();
        kif.key_n = 1'b0;
        tick(10);
        chk("rstmid_kd_before", 32'(kif.key_down), 1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_kd", 32'(kif.key_down), 0);
        chk("rstmid_enter", 32'(kif.enter), 0);
        chk("rstmid_ovr", 32'(kif.override), 0);
        chk("rstmid_state", 32'(dut.state), 0);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        chk("rstmid_kd_e5", 32'(kif.key_down), 0);
        tick(1);
        chk("rstmid_kd_e6", 32'(kif.key_down), 1);
        tick(4);
        kif.key_n = 1'b1;
        tick(7);
        chk("rstmid_enter_e7", 32'(kif.enter), 1);
        tick(5);
        chk("rstmid_enter_cnt", 32'(n_enter - e0), 1);
        chk("rstmid_ovr_cnt", 32'(n_ovr - o0), 0);

        // Two short presses separated by 8 released cycles
        mark();
        kif.key_n = 1'b0;
        tick(10);
        kif.key_n = 1'b1;
        tick(7);
        chk("b2b_enter1_e17", 32'(kif.enter), 1);
        tick(1);
        kif.key_n = 1'b0;
        tick(10);
        kif.key_n = 1'b1;
        tick(7);
        chk("b2b_enter2_e35", 32'(kif.enter), 1);
        tick(1);
        chk("b2b_enter2_e36", 32'(kif.enter), 0);
        tick(10);
        chk("b2b_enter_cnt", 32'(n_enter - e0), 2);
        chk("b2b_ovr_cnt", 32'(n_ovr - o0), 0);

        chk("never_both", 32'(n_both), 0);
        chk("never_wide", 32'(n_wide), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
